alu_opnd_stage: RTL and testbench
=================================

# alu_opnd_stage

Registered operand-select stage between decode and the ALU: chooses both ALU operands from register data, immediate, PC or a constant, and resolves read-after-write hazards by forwarding from the EX and WB stages. The selected operands are held in a pipeline register with valid/ready handshakes on both sides. Load-use hazards stall the upstream for exactly one cycle. Replaces the purely combinational operand-2 multiplexer with a pipelined, hazard-aware stage.

## Interface
- REG_LEN, 32, datapath width in bits
- ADDR_W, 5, register-address width (x0..x31)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- rs1_a, rs2_a  in  ADDR_W  source register addresses
- rs1_d, rs2_d  in  REG_LEN  register-file read data
- imm  in  REG_LEN  decoded immediate
- pc  in  REG_LEN  instruction address
- alu1_sel  in  1  0 = RS (rs1), 1 = PC
- alu2_sel  in  2  0 = RS (rs2), 1 = IMM, 2 = CONST4 (value 4), 3 = zero
- rd_a  in  ADDR_W  destination address, passed through
- ex_wr_en, ex_is_load  in  1  EX-stage instruction writes rd / is a load
- ex_rd_a  in  ADDR_W;  ex_rd_d  in  REG_LEN  EX-stage destination and result
- wb_wr_en  in  1;  wb_rd_a  in  ADDR_W;  wb_rd_d  in  REG_LEN  WB-stage write
- out_valid  out  1  operands valid to ALU
- out_ready  in  1  ALU accepts
- alu_in1, alu_in2  out  REG_LEN  registered operands
- out_rd_a  out  ADDR_W  registered destination

## Operation
- A source register is *used* only if its select is RS (rs1 when alu1_sel=0, rs2 when alu2_sel=0); unused sources never forward or stall.
- Match: used source address ≠ 0 and equals the stage's rd address with that stage's wr_en=1. x0 never forwards.
- Forward priority: EX match → ex_rd_d; else WB match → wb_rd_d; else register-file data.
- Load-use hazard: EX match with ex_is_load=1. Forces in_ready=0; no capture that cycle.
- Non-RS selects: PC → pc, IMM → imm, CONST4 → 32'd4 (zero-extended to REG_LEN), 3 → 0.
- Transfer: capture when in_valid && in_ready. in_ready = (!out_valid || out_ready) && !hazard.
- Output register: set out_valid on capture; clear when out_ready && !capture; hold all outputs while out_valid && !out_ready.
- Simultaneous drain and capture: new operands load, out_valid stays 1.
- States: EMPTY (out_valid=0), FULL (out_valid=1); EMPTY→FULL on capture, FULL→EMPTY on out_ready without capture, FULL→FULL otherwise.

## Timing
- Latency 1 cycle from capture to out_valid; throughput 1 per cycle when no hazard and out_ready=1.
- Load-use stall: exactly one cycle, provided EX advances; in_ready rises the following cycle and WB forwarding supplies the value.
- in_ready is combinational from inputs and state; outputs registered only.
- Reset: out_valid=0, alu_in1=0, alu_in2=0, out_rd_a=0, immediately on rst assertion; an in-flight operand is discarded. First capture possible on the first edge after rst deasserts.

## Configuration
- ALU_OPND_FWD_EN defined: forwarding as above; only load-use stalls.
- Undefined: no forwarding paths; any EX or WB match on a used source is a hazard (in_ready=0) until both stages no longer match; operands always come from register-file data.

## Test plan
- Reset mid-transfer: rst asserted with out_valid=1 → out_valid, alu_in1, alu_in2, out_rd_a all 0 in the same cycle.
- ADDI: alu1_sel=0, alu2_sel=1, rs1_d=10, imm=5, no matches → next cycle alu_in1=10, alu_in2=5, out_valid=1.
- EX/WB priority: rs2_a=3, ex_rd_a=3 (ex_rd_d=7), wb_rd_a=3 (wb_rd_d=9) → alu_in2=7; with ex_wr_en=0 → alu_in2=9.
- x0 and unused: rs1_a=0, ex_rd_a=0 → rs1_d used; rs2_a match with alu2_sel=1 → imm, no stall.
- Load-use: ex_is_load=1, ex_rd_a=rs1_a=4 → in_ready=0 one cycle, then capture with WB value; without ALU_OPND_FWD_EN any match stalls until cleared.
- Backpressure: out_ready=0 for 3 cycles → outputs held, in_ready=0; out_ready=1 with in_valid=1 → drain and capture same cycle, out_valid stays 1.

Source files
------------

// File: rtl/alu_opnd_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_opnd_stage_if : decode -> operand stage -> ALU bundle           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface alu_opnd_stage_if #(
  parameter int REG_LEN = 32,
  parameter int ADDR_W  = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  rs1_a;
  logic [ADDR_W-1:0]  rs2_a;
  logic [REG_LEN-1:0] rs1_d;
  logic [REG_LEN-1:0] rs2_d;
  logic [REG_LEN-1:0] imm;
  logic [REG_LEN-1:0] pc;
  logic               alu1_sel;
  logic [1:0]         alu2_sel;
  logic [ADDR_W-1:0]  rd_a;
  logic               ex_wr_en;
  logic               ex_is_load;
  logic [ADDR_W-1:0]  ex_rd_a;
  logic [REG_LEN-1:0] ex_rd_d;
  logic               wb_wr_en;
  logic [ADDR_W-1:0]  wb_rd_a;
  logic [REG_LEN-1:0] wb_rd_d;
  logic               out_valid;
  logic               out_ready;
  logic [REG_LEN-1:0] alu_in1;
  logic [REG_LEN-1:0] alu_in2;
  logic [ADDR_W-1:0]  out_rd_a;

  modport master (
    output in_valid, rs1_a, rs2_a, rs1_d, rs2_d, imm, pc, alu1_sel, alu2_sel,
           rd_a, ex_wr_en, ex_is_load, ex_rd_a, ex_rd_d, wb_wr_en, wb_rd_a,
           wb_rd_d, out_ready,
    input  in_ready, out_valid, alu_in1, alu_in2, out_rd_a
  );

  modport slave (
    input  in_valid, rs1_a, rs2_a, rs1_d, rs2_d, imm, pc, alu1_sel, alu2_sel,
           rd_a, ex_wr_en, ex_is_load, ex_rd_a, ex_rd_d, wb_wr_en, wb_rd_a,
           wb_rd_d, out_ready,
    output in_ready, out_valid, alu_in1, alu_in2, out_rd_a
  );
endinterface
`default_nettype wire

// File: rtl/alu_opnd_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_opnd_stage : registered, hazard-aware ALU operand select.       |
// | ALU_OPND_FWD_EN enables EX/WB forwarding (else match stalls).      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_opnd_stage #(
  parameter int REG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  alu_opnd_stage_if.slave  bus
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [REG_LEN-1:0] alu_in1_q, alu_in1_d;
  logic [REG_LEN-1:0] alu_in2_q, alu_in2_d;
  logic [ADDR_W-1:0]  out_rd_a_q, out_rd_a_d;

  logic               use1, use2;
  logic               ex_m1, ex_m2, wb_m1, wb_m2;
  logic               hazard, capture, in_ready;
  logic [REG_LEN-1:0] src1, src2, opnd1, opnd2;

  assign use1  = !bus.alu1_sel;
  assign use2  = (bus.alu2_sel == 2'd0);
  // x0 is hard-wired zero, so it never matches a producer
  assign ex_m1 = use1 && (bus.rs1_a != '0) && bus.ex_wr_en && (bus.ex_rd_a == bus.rs1_a);
  assign ex_m2 = use2 && (bus.rs2_a != '0) && bus.ex_wr_en && (bus.ex_rd_a == bus.rs2_a);
  assign wb_m1 = use1 && (bus.rs1_a != '0) && bus.wb_wr_en && (bus.wb_rd_a == bus.rs1_a);
  assign wb_m2 = use2 && (bus.rs2_a != '0) && bus.wb_wr_en && (bus.wb_rd_a == bus.rs2_a);

`ifdef ALU_OPND_FWD_EN
  assign hazard = bus.ex_is_load && (ex_m1 || ex_m2);
  assign src1   = ex_m1 ? bus.ex_rd_d : (wb_m1 ? bus.wb_rd_d : bus.rs1_d);
  assign src2   = ex_m2 ? bus.ex_rd_d : (wb_m2 ? bus.wb_rd_d : bus.rs2_d);
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.ex_rd_d, bus.wb_rd_d, bus.ex_is_load};
  assign hazard = ex_m1 || ex_m2 || wb_m1 || wb_m2;
  assign src1   = bus.rs1_d;
  assign src2   = bus.rs2_d;
`endif

  always_comb begin
    opnd1 = bus.alu1_sel ? bus.pc : src1;
    opnd2 = '0;
    case (bus.alu2_sel)
      2'd0:    opnd2 = src2;
      2'd1:    opnd2 = bus.imm;
      2'd2:    opnd2 = {{(REG_LEN-3){1'b0}}, 3'd4};
      default: opnd2 = '0;
    endcase
  end

  assign in_ready = ((state_q == S_EMPTY) || bus.out_ready) && !hazard;
  assign capture  = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    out_rd_a_d = out_rd_a_q;
    if (capture) begin
      state_d    = S_FULL;
      alu_in1_d  = opnd1;
      alu_in2_d  = opnd2;
      out_rd_a_d = bus.rd_a;
    end else if (bus.out_ready) begin
      state_d    = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      out_rd_a_q <= '0;
    end else begin
      state_q    <= state_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      out_rd_a_q <= out_rd_a_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_FULL);
  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.out_rd_a  = out_rd_a_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_opnd_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_opnd_stage : self-checking bench for alu_opnd_stage          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_alu_opnd_stage;
  typedef struct {
    logic        in_valid;
    logic        out_ready;
    logic        alu1_sel;
    logic [1:0]  alu2_sel;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [31:0] rs1_d, rs2_d, imm, pc;
    logic        ex_wr_en, ex_is_load;
    logic [4:0]  ex_rd_a;
    logic [31:0] ex_rd_d;
    logic        wb_wr_en;
    logic [4:0]  wb_rd_a;
    logic [31:0] wb_rd_d;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic        exp_ready;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } tvec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t cur;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        m_full;
  logic [31:0] m_in1, m_in2;
  logic [4:0]  m_rd;

  always #5 clk = ~clk;

  alu_opnd_stage_if #(.REG_LEN(32), .ADDR_W(5)) bus ();

  assign bus.in_valid   = cur.in_valid;
  assign bus.out_ready  = cur.out_ready;
  assign bus.alu1_sel   = cur.alu1_sel;
  assign bus.alu2_sel   = cur.alu2_sel;
  assign bus.rs1_a      = cur.rs1_a;
  assign bus.rs2_a      = cur.rs2_a;
  assign bus.rd_a       = cur.rd_a;
  assign bus.rs1_d      = cur.rs1_d;
  assign bus.rs2_d      = cur.rs2_d;
  assign bus.imm        = cur.imm;
  assign bus.pc         = cur.pc;
  assign bus.ex_wr_en   = cur.ex_wr_en;
  assign bus.ex_is_load = cur.ex_is_load;
  assign bus.ex_rd_a    = cur.ex_rd_a;
  assign bus.ex_rd_d    = cur.ex_rd_d;
  assign bus.wb_wr_en   = cur.wb_wr_en;
  assign bus.wb_rd_a    = cur.wb_rd_a;
  assign bus.wb_rd_d    = cur.wb_rd_d;

  alu_opnd_stage #(.REG_LEN(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic vec_t idle();
    vec_t v;
    v = '{in_valid: 1'b1, out_ready: 1'b1, alu1_sel: 1'b0, alu2_sel: 2'd0,
          rs1_a: 5'd0, rs2_a: 5'd0, rd_a: 5'd0, rs1_d: 32'd0, rs2_d: 32'd0,
          imm: 32'd0, pc: 32'd0, ex_wr_en: 1'b0, ex_is_load: 1'b0,
          ex_rd_a: 5'd0, ex_rd_d: 32'd0, wb_wr_en: 1'b0, wb_rd_a: 5'd0,
          wb_rd_d: 32'd0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Value a source register should read and whether it blocks issue
  function automatic void model_src(input logic used, input logic [4:0] a,
                                    input logic [31:0] rf, output logic [31:0] val,
                                    output logic haz);
    logic in_ex, in_wb;
    in_ex = used && a != 0 && cur.ex_wr_en && cur.ex_rd_a == a;
    in_wb = used && a != 0 && cur.wb_wr_en && cur.wb_rd_a == a;
`ifdef ALU_OPND_FWD_EN
    haz = in_ex && cur.ex_is_load;
    val = in_ex ? cur.ex_rd_d : in_wb ? cur.wb_rd_d : rf;
`else
    haz = in_ex || in_wb;
    val = rf;
`endif
  endfunction

  // Called at posedge+1 with cur applied; returns at the next posedge+1
  task automatic run_cycle(input string tag, output logic rdy);
    logic [31:0] v1, v2;
    logic h1, h2, exp_rdy, cap;
    #2;
    model_src(cur.alu1_sel == 1'b0, cur.rs1_a, cur.rs1_d, v1, h1);
    model_src(cur.alu2_sel == 2'd0, cur.rs2_a, cur.rs2_d, v2, h2);
    if (cur.alu1_sel) v1 = cur.pc;
    case (cur.alu2_sel)
      2'd1: v2 = cur.imm;
      2'd2: v2 = 32'd4;
      2'd3: v2 = 32'd0;
      default: ;
    endcase
    exp_rdy = (!m_full || cur.out_ready) && !(h1 || h2);
    rdy = bus.in_ready;
    check({tag, "_in_ready"}, {31'd0, rdy}, {31'd0, exp_rdy});
    cap = cur.in_valid && exp_rdy;
    @(posedge clk);
    #1;
    if (cap) begin
      m_full = 1'b1; m_in1 = v1; m_in2 = v2; m_rd = cur.rd_a;
    end else if (cur.out_ready) begin
      m_full = 1'b0;
    end
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_full});
    check({tag, "_alu_in1"}, bus.alu_in1, m_in1);
    check({tag, "_alu_in2"}, bus.alu_in2, m_in2);
    check({tag, "_out_rd_a"}, {27'd0, bus.out_rd_a}, {27'd0, m_rd});
  endtask

  initial begin
    tvec_t tbl[6];
    logic  r;
    vec_t  v;

    for (int i = 0; i < 6; i++) begin
      tbl[i].v = idle();
      tbl[i].exp_ready = 1'b1;
    end
    // ADDI x1 + 5
    tbl[0].v.alu2_sel = 2'd1; tbl[0].v.rs1_a = 5'd1; tbl[0].v.rs1_d = 32'd10;
    tbl[0].v.imm = 32'd5; tbl[0].v.rd_a = 5'd2;
    tbl[0].exp1 = 32'd10; tbl[0].exp2 = 32'd5;
    // x0 never matches even a load in EX
    tbl[1].v.alu2_sel = 2'd3; tbl[1].v.rs1_d = 32'h11; tbl[1].v.ex_wr_en = 1'b1;
    tbl[1].v.ex_is_load = 1'b1; tbl[1].v.ex_rd_d = 32'd99;
    tbl[1].exp1 = 32'h11; tbl[1].exp2 = 32'd0;
    // unused rs2 matching a load does not stall
    tbl[2].v.alu1_sel = 1'b1; tbl[2].v.pc = 32'h100; tbl[2].v.alu2_sel = 2'd1;
    tbl[2].v.imm = 32'h20; tbl[2].v.rs2_a = 5'd6; tbl[2].v.ex_wr_en = 1'b1;
    tbl[2].v.ex_rd_a = 5'd6; tbl[2].v.ex_is_load = 1'b1;
    tbl[2].exp1 = 32'h100; tbl[2].exp2 = 32'h20;
    // PC + CONST4
    tbl[3].v.alu1_sel = 1'b1; tbl[3].v.pc = 32'h1000; tbl[3].v.alu2_sel = 2'd2;
    tbl[3].v.rd_a = 5'd31;
    tbl[3].exp1 = 32'h1000; tbl[3].exp2 = 32'd4;
    // both RS, WB writes an unrelated register
    tbl[4].v.rs1_a = 5'd2; tbl[4].v.rs2_a = 5'd3; tbl[4].v.rs1_d = 32'hA;
    tbl[4].v.rs2_d = 32'hB; tbl[4].v.wb_wr_en = 1'b1; tbl[4].v.wb_rd_a = 5'd7;
    tbl[4].exp1 = 32'hA; tbl[4].exp2 = 32'hB;
    // unused rs1 matching WB
    tbl[5].v.alu1_sel = 1'b1; tbl[5].v.pc = 32'h44; tbl[5].v.alu2_sel = 2'd3;
    tbl[5].v.rs1_a = 5'd5; tbl[5].v.wb_wr_en = 1'b1; tbl[5].v.wb_rd_a = 5'd5;
    tbl[5].exp1 = 32'h44; tbl[5].exp2 = 32'd0;

    cur = idle();
    cur.in_valid = 1'b0;
    m_full = 1'b0; m_in1 = 32'd0; m_in2 = 32'd0; m_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_alu_in1", bus.alu_in1, 32'd0);
    check("rst_alu_in2", bus.alu_in2, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cur = tbl[i].v;
      run_cycle($sformatf("tbl%0d", i), r);
      check($sformatf("tbl%0d_ready_const", i), {31'd0, r}, {31'd0, tbl[i].exp_ready});
      check($sformatf("tbl%0d_in1_const", i), bus.alu_in1, tbl[i].exp1);
      check($sformatf("tbl%0d_in2_const", i), bus.alu_in2, tbl[i].exp2);
    end

    // EX/WB priority on rs2
    v = idle();
    v.alu1_sel = 1'b1; v.rs2_a = 5'd3; v.rs2_d = 32'd1;
    v.ex_wr_en = 1'b1; v.ex_rd_a = 5'd3; v.ex_rd_d = 32'd7;
    v.wb_wr_en = 1'b1; v.wb_rd_a = 5'd3; v.wb_rd_d = 32'd9;
    cur = v;
`ifdef ALU_OPND_FWD_EN
    run_cycle("prio_ex", r);
    check("prio_ex_val", bus.alu_in2, 32'd7);
    cur.ex_wr_en = 1'b0;
    run_cycle("prio_wb", r);
    check("prio_wb_val", bus.alu_in2, 32'd9);
`else
    run_cycle("prio_stall_ex", r);
    check("prio_stall_ex_rdy", {31'd0, r}, 32'd0);
    cur.ex_wr_en = 1'b0;
    run_cycle("prio_stall_wb", r);
    check("prio_stall_wb_rdy", {31'd0, r}, 32'd0);
    cur.wb_wr_en = 1'b0;
    run_cycle("prio_clear", r);
    check("prio_clear_val", bus.alu_in2, 32'd1);
`endif

    // Load-use on rs1 = x4
    v = idle();
    v.rs1_a = 5'd4; v.rs1_d = 32'h33; v.alu2_sel = 2'd3;
    v.ex_wr_en = 1'b1; v.ex_is_load = 1'b1; v.ex_rd_a = 5'd4; v.ex_rd_d = 32'hDEAD;
    cur = v;
    run_cycle("ld_stall", r);
    check("ld_stall_rdy", {31'd0, r}, 32'd0);
    cur.ex_wr_en = 1'b0; cur.ex_is_load = 1'b0;
    cur.wb_wr_en = 1'b1; cur.wb_rd_a = 5'd4; cur.wb_rd_d = 32'h55;
`ifdef ALU_OPND_FWD_EN
    run_cycle("ld_fwd", r);
    check("ld_fwd_val", bus.alu_in1, 32'h55);
`else
    run_cycle("ld_wb_stall", r);
    check("ld_wb_stall_rdy", {31'd0, r}, 32'd0);
    cur.wb_wr_en = 1'b0;
    run_cycle("ld_clear", r);
    check("ld_clear_val", bus.alu_in1, 32'h33);
`endif

    // Backpressure: hold three cycles, then drain and capture together
    v = idle();
    v.alu2_sel = 2'd1; v.rs1_d = 32'hAA; v.imm = 32'hBB; v.rd_a = 5'd9;
    cur = v;
    run_cycle("bp_load", r);
    cur.out_ready = 1'b0; cur.rs1_d = 32'hCC; cur.imm = 32'hDD; cur.rd_a = 5'd10;
    for (int i = 0; i < 3; i++) begin
      run_cycle($sformatf("bp_hold%0d", i), r);
      check($sformatf("bp_hold%0d_rdy", i), {31'd0, r}, 32'd0);
      check($sformatf("bp_hold%0d_in1", i), bus.alu_in1, 32'hAA);
    end
    cur.out_ready = 1'b1;
    run_cycle("bp_drain", r);
    check("bp_drain_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_drain_in1", bus.alu_in1, 32'hCC);

    // Asynchronous reset while a result is pending
    cur.out_ready = 1'b0; cur.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rstmid_in1", bus.alu_in1, 32'd0);
    check("rstmid_in2", bus.alu_in2, 32'd0);
    check("rstmid_rd", {27'd0, bus.out_rd_a}, 32'd0);
    m_full = 1'b0; m_in1 = 32'd0; m_in2 = 32'd0; m_rd = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = idle();
      v.in_valid   = ($urandom_range(0, 3) != 0);
      v.out_ready  = ($urandom_range(0, 3) != 0);
      v.alu1_sel   = 1'($urandom_range(0, 1));
      v.alu2_sel   = 2'($urandom_range(0, 3));
      v.rs1_a      = 5'($urandom_range(0, 7));
      v.rs2_a      = 5'($urandom_range(0, 7));
      v.rd_a       = 5'($urandom_range(0, 31));
      v.rs1_d      = $urandom;
      v.rs2_d      = $urandom;
      v.imm        = $urandom;
      v.pc         = $urandom;
      v.ex_wr_en   = 1'($urandom_range(0, 1));
      v.ex_is_load = ($urandom_range(0, 3) == 0);
      v.ex_rd_a    = 5'($urandom_range(0, 7));
      v.ex_rd_d    = $urandom;
      v.wb_wr_en   = 1'($urandom_range(0, 1));
      v.wb_rd_a    = 5'($urandom_range(0, 7));
      v.wb_rd_d    = $urandom;
      cur = v;
      run_cycle("rnd", r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
